// File: rtl/t1_retire_watchdog.sv
// Retire-progress watchdog producing the sticky sim-control status byte (0 run, 255 done, else error).
// Optional retire/gap statistics are enabled by defining T1_WATCHDOG_STATS_EN.
module t1_retire_watchdog #(
    parameter int TIMEOUT_W     = 32,
    parameter int DRAIN_CYCLES  = 64,
    parameter int OUTSTANDING_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [TIMEOUT_W-1:0]     timeout_limit,
    input  logic                     retire_valid,
    input  logic                     quit_valid,
    input  logic [7:0]               quit_code,
    input  logic [OUTSTANDING_W-1:0] outstanding,
    output logic [7:0]               status,
    output logic [7:0]               fail_code,
    output logic [TIMEOUT_W-1:0]     idle_cycles,
    output logic [63:0]              retired_total,
    output logic [TIMEOUT_W-1:0]     max_gap
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_ERROR} state_t;

    state_t               state_q, state_d;
    logic [7:0]           status_q, status_d;
    logic [7:0]           fail_q, fail_d;
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 active;
    logic                 gap_timeout;

    assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
    // The gap expires on the edge whose idle count would reach the limit.
    assign gap_timeout = (timeout_limit != '0) && (idle_q == timeout_limit - TIMEOUT_W'(1));

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        fail_d   = fail_q;
        idle_d   = idle_q;
        drain_d  = drain_q;
        if (active) begin
            if (retire_valid)
                idle_d = '0;
            else if (idle_q != '1)
                idle_d = idle_q + TIMEOUT_W'(1);
        end
        case (state_q)
            S_RUN: begin
                if (quit_valid && quit_code != 8'd0) begin
                    state_d  = S_ERROR;
                    status_d = 8'd2;
                    fail_d   = quit_code;
                end else if (quit_valid) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (!retire_valid && gap_timeout) begin
                    state_d  = S_ERROR;
                    status_d = 8'd1;
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    state_d  = S_DONE;
                    status_d = 8'd255;
                end else if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d  = S_ERROR;
                    status_d = 8'd3;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            status_q <= '0;
            fail_q   <= '0;
            idle_q   <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            fail_q   <= fail_d;
            idle_q   <= idle_d;
            drain_q  <= drain_d;
        end
    end

    assign status      = status_q;
    assign fail_code   = fail_q;
    assign idle_cycles = idle_q;

`ifdef T1_WATCHDOG_STATS_EN
    logic [63:0]          retired_q, retired_d;
    logic [TIMEOUT_W-1:0] max_gap_q, max_gap_d;

    always_comb begin
        retired_d = retired_q;
        max_gap_d = max_gap_q;
        if (active && retire_valid) begin
            retired_d = retired_q + 64'd1;
            if (idle_q > max_gap_q)
                max_gap_d = idle_q;
        end
        // A gap that ends in a timeout never closes, so record it as it trips.
        if (state_q == S_RUN && state_d == S_ERROR && status_d == 8'd1 && idle_d > max_gap_q)
            max_gap_d = idle_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
            max_gap_q <= '0;
        end else begin
            retired_q <= retired_d;
            max_gap_q <= max_gap_d;
        end
    end

    assign retired_total = retired_q;
    assign max_gap       = max_gap_q;
`else
    assign retired_total = '0;
    assign max_gap       = '0;
`endif
endmodule

// File: doc/t1_retire_watchdog.md
# t1_retire_watchdog

Synthesizable progress monitor inside the T1 emulation top that produces the per-cycle simulation status byte polled by the testbench sim-control DPI loop. It tracks vector-instruction retirement, detects retire-gap timeouts, accepts the DUT's end-of-test quit request, waits for in-flight work to drain, and reports a sticky status code: 0 = continue, 255 = finished OK, other = error.

## Interface
- `TIMEOUT_W`, default 32: width of the retire-gap counter and of `timeout_limit`.
- `DRAIN_CYCLES`, default 64: maximum cycles allowed in DRAIN before a drain error.
- `OUTSTANDING_W`, default 8: width of the `outstanding` count.

- `clock`  in  1: sole clock; all state is posedge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `timeout_limit`  in  TIMEOUT_W: maximum consecutive non-retire cycles; 0 disables the gap check. Quasi-static.
- `retire_valid`  in  1: one vector instruction retires this cycle.
- `quit_valid`  in  1: DUT requests end of test this cycle.
- `quit_code`  in  8: 0 = pass, nonzero = test failure; sampled only with `quit_valid`.
- `outstanding`  in  OUTSTANDING_W: instructions currently in flight.
- `status`  out  8: registered status byte: 0 run, 255 done, 1 gap timeout, 2 test fail, 3 drain timeout.
- `fail_code`  out  8: registered copy of `quit_code` captured on a failing quit; 0 otherwise.
- `idle_cycles`  out  TIMEOUT_W: current retire-gap count.
- `retired_total`  out  64: retire counter (see Configuration).
- `max_gap`  out  TIMEOUT_W: largest gap seen (see Configuration).

## Operation
- States: RUN, DRAIN, DONE, ERROR. Reset enters RUN; all outputs reset to 0.
- Idle counter: each cycle in RUN or DRAIN, cleared to 0 if `retire_valid`, else increments, saturating at all-ones.
- RUN, priority highest first:
  - `quit_valid` with `quit_code != 0`: ERROR, `status` = 2, `fail_code` = `quit_code`.
  - `quit_valid` with `quit_code == 0`: DRAIN, drain counter cleared.
  - `retire_valid`: stay in RUN.
  - `timeout_limit != 0` and idle count == `timeout_limit - 1`: ERROR, `status` = 1.
- DRAIN: `quit_valid` is ignored, and the gap check is disabled.
  - `outstanding == 0`: DONE, `status` = 255.
  - Otherwise the drain counter increments. When it reaches `DRAIN_CYCLES - 1` with `outstanding != 0`: ERROR, `status` = 3.
- DONE and ERROR are sticky until reset. All inputs are ignored, and `status`, `fail_code` and `idle_cycles` hold their values.
- Retire and timeout in the same cycle: the retire wins and no error is raised.
- Quit and timeout in the same cycle: the quit wins.

## Timing
- `status` is registered: an event sampled at edge N is visible after edge N.
- Gap timeout: with limit L, after L consecutive edges sampling `retire_valid` = 0 in RUN, `status` = 1 after the L-th edge.
- Passing quit with `outstanding` = 0 at the quit edge: `status` = 255 one edge later (quit edge to DRAIN, next edge to DONE).
- Reset assertion takes effect asynchronously, mid-operation included, returning all state to RUN and outputs to 0. Deassertion is expected to be synchronized upstream.

## Configuration
- `T1_WATCHDOG_STATS_EN` defined:
  - `retired_total` counts every `retire_valid` in RUN and DRAIN, wrapping at 2^64.
  - `max_gap` holds the maximum idle count reached. It updates on the cycle the gap closes, or in the cycle entering ERROR for status 1.
- Not defined: `retired_total` and `max_gap` are tied to 0, with no registers inferred.

## Test plan
- Reset, then `retire_valid` every cycle for 100 cycles with `timeout_limit` = 10 -> `status` stays 0; `retired_total` = 100 when STATS_EN is defined.
- `timeout_limit` = 5, one retire, then none -> `status` = 1 exactly after the 5th idle edge. A retire on the 5th cycle instead keeps `status` = 0.
- `quit_valid` with `quit_code` = 0x2A -> `status` = 2 and `fail_code` = 0x2A next cycle. A later `quit_valid` with code 0 leaves both unchanged.
- Passing quit with `outstanding` = 3, dropping to 0 after 4 cycles -> `status` = 255 the cycle after `outstanding` reads 0.
- Passing quit with `outstanding` held at 1, `DRAIN_CYCLES` = 64 -> `status` = 3 after 64 drain cycles. Asserting `reset` = 0 mid-drain instead returns `status` to 0 immediately.
- `timeout_limit` = 0 with no retires for 10000 cycles -> `status` = 0 and `idle_cycles` = 10000.
